uart_tx_byte_fifo: RTL and testbench

- Buffers outgoing bytes ahead of the UART controller's transmit port.
- Presents them one at a time on the controller's tx_data/tx_en interface, paced by tx_busy.
- Lets bursty producers (register read-back, status/telemetry generators) queue up to DEPTH bytes without tracking UART timing.
- Directly upstream of the UART controller's TX input.

---
 rtl/uart_tx_byte_fifo_if.sv | 36 +++
 rtl/uart_tx_byte_fifo.sv | 146 ++++++++++++++
 tb/tb_uart_tx_byte_fifo.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_byte_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte_fifo_if
//  Description : Producer-side byte handshake plus the UART controller TX
//                port (tx_data / tx_en / tx_busy) used by uart_tx_byte_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_byte_fifo_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_busy;

    // Environment side: producer plus UART controller
    modport master (
        output in_data,
        output in_valid,
        output tx_busy,
        input  in_ready,
        input  tx_data,
        input  tx_en
    );

    // FIFO side
    modport slave (
        input  in_data,
        input  in_valid,
        input  tx_busy,
        output in_ready,
        output tx_data,
        output tx_en
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte_fifo
//  Description : DEPTH x 8 circular byte buffer in front of a UART controller.
//                A small drain FSM pops one byte at a time, strobes tx_en for
//                one cycle and then follows tx_busy (with a rise timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte_fifo #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    uart_tx_byte_fifo_if.slave bus,
    input  wire logic          flush,
    output logic [AW:0]        level,
    output logic               empty,
    output logic               overflow,
    output logic               timeout
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOAD      = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    localparam int          TW         = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_inc;
    logic [7:0]    tx_data_q;
    logic          tx_en_q;
    logic          full;
    logic          push;
    logic          pop;

    assign full         = (level == LEVEL_FULL);
    assign empty        = (level == '0);
    assign bus.in_ready = ~full;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_en    = tx_en_q;
    assign timer_inc    = timer + 1'b1;

    // flush beats both a push and a pop sampled on the same edge
    assign push = bus.in_valid & ~full & ~flush;
    assign pop  = (state == S_IDLE) & ~empty & ~bus.tx_busy & ~flush;

    // Byte storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // Pointers and occupancy counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Dropped-byte indicator: one cycle after a push attempt while full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= bus.in_valid & full;
        end
    end

    // Drain FSM: load head byte, strobe tx_en, then track tx_busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            tx_en_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tx_data_q <= mem[rd_ptr];
                        tx_en_q   <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    timer <= '0;
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else begin
                        timer <= timer_inc;
                        // Give up once the timer reaches its last count; the
                        // byte is treated as sent and never re-queued.
                        if (timer_inc == TIMER_LAST) begin
                            timeout <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_byte_fifo
//  Description : Self-checking bench for uart_tx_byte_fifo: directed phases
//                with random payloads, a queue-based scoreboard and a
//                behavioural UART that holds tx_busy for frame_len clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_byte_fifo;
    localparam int DEPTH        = 16;
    localparam int AW           = 4;
    localparam int BUSY_TIMEOUT = 64;
    localparam int SLOW_FRAME   = 100;
    localparam int FAST_FRAME   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [AW:0] level;
    logic        empty;
    logic        overflow;
    logic        timeout;

    uart_tx_byte_fifo_if bus ();

    uart_tx_byte_fifo #(
        .DEPTH        (DEPTH),
        .AW           (AW),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .flush    (flush),
        .level    (level),
        .empty    (empty),
        .overflow (overflow),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural UART: frame_len==0 means tx_busy never rises
    int   frame_len  = 0;
    logic force_busy = 1'b0;
    int   busy_left  = 0;
    always @(negedge clk) begin
        if (busy_left > 0) busy_left--;
        if (rst_n === 1'b1 && bus.tx_en === 1'b1 && frame_len > 0) busy_left = frame_len;
        bus.tx_busy = force_busy || (busy_left > 0);
    end

    // Scoreboard: queue of accepted bytes, occupancy from the push/pop rules
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         mlevel = 0;
    logic [7:0] last_tx_data = 8'h00;
    int         sent_cyc[$];
    logic [7:0] sent_data[$];
    int         timeout_cyc[$];

    always @(posedge clk) begin
        logic       s_valid;
        logic       s_flush;
        logic [7:0] s_data;
        int         lvl_before;
        logic       exp_ovf;
        cyc++;
        s_valid = bus.in_valid;
        s_data  = bus.in_data;
        s_flush = flush;
        #1;
        if (rst_n !== 1'b1) begin
            exp_q.delete();
            mlevel       = 0;
            last_tx_data = 8'h00;
        end else begin
            lvl_before = mlevel;
            exp_ovf    = s_valid && (lvl_before == DEPTH);
            if (bus.tx_en === 1'b1) begin
                sent_cyc.push_back(cyc);
                sent_data.push_back(bus.tx_data);
                check("pop_legal", (exp_q.size() != 0) && !s_flush, 1);
                if (exp_q.size() != 0 && !s_flush) begin
                    check("tx_data", bus.tx_data, exp_q.pop_front());
                    mlevel--;
                end
            end else begin
                check("tx_data_hold", bus.tx_data, last_tx_data);
            end
            last_tx_data = bus.tx_data;
            if (s_flush) begin
                exp_q.delete();
                mlevel = 0;
            end else if (s_valid && lvl_before != DEPTH) begin
                exp_q.push_back(s_data);
                mlevel++;
            end
            check("level", level, mlevel);
            check("empty", empty, mlevel == 0);
            check("in_ready", bus.in_ready, mlevel != DEPTH);
            check("overflow", overflow, exp_ovf);
            if (timeout === 1'b1) timeout_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_sent(input int n, input int budget, input string tag);
        int k = 0;
        while (sent_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, sent_cyc.size() >= n, 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        int quiet = 0;
        while ((exp_q.size() != 0 || quiet < 4) && k < budget) begin
            tick();
            k++;
            quiet = (bus.tx_busy === 1'b0) ? quiet + 1 : 0;
        end
        check(tag, k < budget, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lc;
        int k;
        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #1;
        check("rst_tx_en", bus.tx_en, 0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_overflow", overflow, 0);
        check("rst_timeout", timeout, 0);
        repeat (3) tick();
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) tick();

        // Single byte: latency and data
        frame_len = 20;
        base = sent_cyc.size();
        push(8'hA5);
        lc = cyc;
        wait_sent(base + 1, 50, "t1_sent");
        check("t1_latency", sent_cyc[base] - lc, 1);
        check("t1_data", sent_data[base], 8'hA5);
        wait_idle(200, "t1_idle");
        check("t1_empty", empty, 1);

        // Fill while foreign traffic holds tx_busy, overflow, ordered drain
        frame_len  = SLOW_FRAME;
        force_busy = 1'b1;
        tick();
        base = sent_cyc.size();
        for (int i = 0; i < DEPTH; i++) push(i[7:0]);
        check("t2_full_level", level, DEPTH);
        check("t2_in_ready", bus.in_ready, 0);
        check("t2_no_load_busy", sent_cyc.size(), base);
        push(8'h10);
        check("t2_overflow", overflow, 1);
        tick();
        check("t2_ovf_pulse", overflow, 0);
        check("t2_level_kept", level, DEPTH);
        force_busy = 1'b0;
        wait_sent(base + DEPTH, DEPTH * (SLOW_FRAME + 2) + 100, "t2_sent");
        for (int i = 0; i < DEPTH; i++) check("t2_order", sent_data[base + i], i);
        for (int i = 1; i < DEPTH; i++)
            check("t2_spacing", sent_cyc[base + i] - sent_cyc[base + i - 1], SLOW_FRAME + 2);
        wait_idle(400, "t2_idle");
        check("t2_count", sent_cyc.size(), base + DEPTH);
        check("t2_no_timeout", timeout_cyc.size(), 0);

        // Near-full steady state: push lands on the same edge as each pop
        frame_len  = FAST_FRAME;
        force_busy = 1'b1;
        tick();
        base = sent_cyc.size();
        for (int i = 0; i < DEPTH; i++) push(8'($urandom));
        force_busy = 1'b0;
        wait_sent(base + 1, 20, "t3_first");
        for (int n = 0; n < 40; n++) begin
            repeat (FAST_FRAME + 1) begin
                tick();
                check("t3_level", level, DEPTH - 1);
            end
            bus.in_data  = 8'($urandom);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            check("t3_pop_align", bus.tx_en, 1);
            check("t3_level_pp", level, DEPTH - 1);
        end
        wait_idle(DEPTH * (FAST_FRAME + 2) + 100, "t3_idle");
        check("t3_count", sent_cyc.size(), base + DEPTH + 40);

        // tx_busy never rises: timeout after BUSY_TIMEOUT clocks
        frame_len = 0;
        base = sent_cyc.size();
        push(8'h3C);
        wait_sent(base + 1, 20, "t4_sent");
        lc = sent_cyc[base];
        k = 0;
        while (timeout_cyc.size() < 1 && k < 2 * BUSY_TIMEOUT) begin
            tick();
            k++;
        end
        check("t4_timeout_seen", timeout_cyc.size(), 1);
        if (timeout_cyc.size() >= 1) check("t4_timeout_delay", timeout_cyc[0] - lc, BUSY_TIMEOUT);
        tick();
        check("t4_timeout_pulse", timeout, 0);
        frame_len = 10;
        push(8'h3D);
        wait_sent(base + 2, 20, "t4_next_sent");
        check("t4_next_data", sent_data[base + 1], 8'h3D);
        wait_idle(200, "t4_idle");
        check("t4_single_timeout", timeout_cyc.size(), 1);

        // Flush during WAIT_DONE of the first byte, with a push in that cycle
        frame_len  = 20;
        force_busy = 1'b1;
        tick();
        base = sent_cyc.size();
        for (int i = 0; i < 5; i++) push(8'h21 + i[7:0]);
        force_busy = 1'b0;
        wait_sent(base + 1, 20, "t5_first");
        repeat (5) tick();
        flush        = 1'b1;
        bus.in_data  = 8'hEE;
        bus.in_valid = 1'b1;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("t5_level", level, 0);
        check("t5_no_ovf", overflow, 0);
        repeat (60) tick();
        check("t5_no_more_tx", sent_cyc.size(), base + 1);
        check("t5_first_data", sent_data[base], 8'h21);
        check("t5_empty", empty, 1);
        push(8'h77);
        wait_sent(base + 2, 20, "t5_after_sent");
        check("t5_after_data", sent_data[base + 1], 8'h77);
        wait_idle(200, "t5_idle");

        // Asynchronous reset while tx_en is high
        frame_len = 20;
        base = sent_cyc.size();
        push(8'h11);
        push(8'h12);
        wait_sent(base + 1, 20, "t6_sent");
        #1 rst_n = 1'b0;
        #1;
        check("t6_tx_en", bus.tx_en, 0);
        check("t6_level", level, 0);
        check("t6_empty", empty, 1);
        check("t6_in_ready", bus.in_ready, 1);
        check("t6_tx_data", bus.tx_data, 8'h00);
        repeat (2) tick();
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (30) tick();
        check("t6_quiet", sent_cyc.size(), base + 1);
        push(8'h5A);
        lc = cyc;
        wait_sent(base + 2, 20, "t6_new_sent");
        check("t6_new_latency", sent_cyc[base + 1] - lc, 1);
        check("t6_new_data", sent_data[base + 1], 8'h5A);
        wait_idle(200, "t6_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
